// File: rtl/riscv_core_pkg.sv
// Shared core constants and the fetch queue entry type.
// The fetch stage and its queue both import this package.
package riscv_core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs.
// Flush empties the queue and overrides a push or pop in the same cycle.
module fetch_queue
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_entry,
  output fetch_entry_t  rd_entry,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, in-order response buffering,
// and redirect handling that discards responses to requests already in flight.
module fetch_unit
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   q_count;
  logic            q_empty, q_full;
  logic            q_push, q_pop;
  fetch_entry_t    q_wr_entry, q_head;

  logic            accept, stale, live;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] redirect_tgt;

  assign occupancy    = {1'b0, outstanding_q} + {1'b0, q_count};
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // rst_n gates the request so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign stale = (drop_cnt_q != '0);
  assign live  = imem_rsp_valid && !stale;

  assign q_push     = live && !redirect_valid;
  assign q_pop      = instr_valid && instr_ready && !redirect_valid;
  assign q_wr_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q - CW'(imem_rsp_valid && stale);
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      // Every request still in flight after this cycle's response is stale.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (live)   rsp_pc_d   = rsp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .wr_entry (q_wr_entry),
    .rd_entry (q_head),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign instr_valid = !q_empty;
  assign instr_data  = q_head.instr;
  assign instr_pc    = q_head.pc;

  a_drop_le_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= outstanding_q);
  a_capacity : assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= (CW+1)'(QDEPTH));
  a_no_live_at_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(live && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model that
// tags each in-flight request as live or stale and tracks the expected queue.
module tb_fetch_unit;
  import riscv_core_pkg::*;

  localparam int          QD     = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t mq[$];
  logic [31:0]  exp_fetch;
  int           total = 0;
  int           bad   = 0;
  int           pops  = 0;
  int           redirs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    pend.delete();
    mq.delete();
    exp_fetch = RST_PC;
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
  endtask

  task automatic step(input int p_rdy, input int p_rsp, input int p_ir, input int p_redir);
    pend_t e;
    bit    exp_rv;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_rdy);
    instr_ready    = ($urandom_range(99) < p_ir);
    redirect_valid = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0: redirect_pc = 32'h0000_0100;
      1: redirect_pc = 32'h0000_0103;
      2: redirect_pc = 32'hFFFF_FFF9;
      default: redirect_pc = $urandom();
    endcase
    imem_rsp_valid = (pend.size() != 0) && ($urandom_range(99) < p_rsp);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend[0].addr) : $urandom();
    #1;
    exp_rv = !redirect_valid && (pend.size() + mq.size() < QD);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, exp_fetch);
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr_data", instr_data, mq[0].instr);
    end
    if (mq.size() != 0 && instr_ready && !redirect_valid) begin
      void'(mq.pop_front());
      pops++;
    end
    if (imem_rsp_valid) begin
      e = pend.pop_front();
      if (!e.stale && !redirect_valid)
        mq.push_back('{pc: e.addr, instr: mem_word(e.addr)});
    end
    if (redirect_valid) begin
      redirs++;
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else if (exp_rv && imem_req_ready) begin
      pend.push_back('{addr: exp_fetch, stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  task automatic run_phase(input int n, input int p_rdy, input int p_rsp, input int p_ir,
                           input int p_redir);
    for (int i = 0; i < n; i++) step(p_rdy, p_rsp, p_ir, p_redir);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr_data"}, instr_data, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, wrapping through 0 from RESET_PC
    run_phase(30, 100, 100, 100, 0);
    // decode stalled: queue fills, requests stop, head holds
    run_phase(12, 100, 100, 0, 0);
    run_phase(20, 100, 100, 100, 0);
    // mixed traffic with redirects
    run_phase(400, 70, 60, 70, 8);
    run_phase(150, 100, 100, 100, 25);
    run_phase(100, 100, 100, 50, 3);

    // fill the queue, then reset mid-cycle
    run_phase(10, 100, 100, 0, 0);
    chk("full_before_reset", 32'(mq.size()), 32'(QD));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(30, 100, 100, 100, 0);
    run_phase(100, 80, 70, 80, 5);

    chk("pops_seen", 32'(pops > 100), 32'd1);
    chk("redirects_seen", 32'(redirs > 10), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
